logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Registered, parametrised bitwise logic unit; next generation of the 4/8-bit combinational logic generator.
//  Adds 8 functions, valid/ready handshake on both sides, one-cycle output register with backpressure,
//  and an accumulate mode that feeds the previous result back as operand B. Sits between operand
//  sources and downstream datapath consumers that may stall.
// PARAMETERS
//  WIDTH     8   operand/result width in bits (>=1)
//  CNT_W     16  width of accepted-transaction counter
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       synchronous active-low reset, sampled on rising clk
//  in_valid   in   1       operand beat valid
//  in_ready   out  1       unit can accept a beat this cycle
//  A          in   WIDTH   operand A
//  B          in   WIDTH   operand B (ignored when acc_mode=1)
//  logic_func in   3       function select (see BEHAVIOUR)
//  acc_mode   in   1       1: B operand := acc register
//  acc_clr    in   1       clear acc register to 0
//  out_valid  out  1       logic_out holds an unconsumed result
//  out_ready  in   1       downstream accepts result
//  logic_out  out  WIDTH   registered result
//  txn_count  out  CNT_W   number of accepted input beats, wraps
//  out_zero   out  1       (LOGIC_FLAGS_EN only) logic_out == 0
//  out_parity out  1       (LOGIC_FLAGS_EN only) XOR-reduce of logic_out
// BEHAVIOUR
//  - Functions: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 NAND, 101 NOR, 110 XNOR, 111 PASS A.
//  - Operand Bop = acc_mode ? acc : B; result computed bitwise over WIDTH, no carries.
//  - Accept = in_valid & in_ready. in_ready = ~out_valid | out_ready (combinational, no bubble).
//  - Latency 1: accepted beat in cycle N -> logic_out/out_valid=1 from cycle N+1.
//  - Hold: while out_valid & ~out_ready, logic_out, out_valid stable; in_ready=0; inputs ignored.
//  - Drain: out_ready & ~accept -> out_valid=0 next cycle; logic_out keeps last value.
//  - Simultaneous drain+accept: new result replaces old next cycle, out_valid stays 1 (full throughput).
//  - acc register: on accept, acc <= result. acc_clr forces acc <= 0 next cycle; acc_clr with accept in
//    same cycle: result uses old acc as Bop, acc <= 0 (clear wins over update).
//  - txn_count += 1 per accept, wraps 2^CNT_W-1 -> 0; not affected by acc_clr.
//  - Reset (any cycle, incl. mid-hold): out_valid=0, logic_out=0, acc=0, txn_count=0, flags=1/0
//    (out_zero=1, out_parity=0); in_ready=1 in the cycle after reset deasserts; pending result discarded.
//  - in_valid may drop without acceptance; no X propagates to logic_out when in_valid=0.
// CONFIGURATION
//  - LOGIC_FLAGS_EN defined: out_zero/out_parity ports exist, registered with logic_out (same latency,
//    same hold/reset rules).
//  - LOGIC_FLAGS_EN undefined: ports absent; no flag logic; all other behaviour identical.
// TESTING
//  1. W=4, A=0110, B=1100, func 0..7 back-to-back, out_ready=1 -> 0100,1110,1010,1001,1011,0001,0101,0110
//     one cycle after each accept; in_ready=1 throughout; txn_count=8.
//  2. W=8, A=10101010, B=01010101, func=010, out_ready=0 for 3 cycles -> logic_out=FF held, out_valid=1,
//     in_ready=0, next beat not taken until out_ready=1.
//  3. W=8 acc: acc_clr, then acc_mode=1 func=001 A=01,02,04,08 -> outputs 01,03,07,0F; acc_clr+accept
//     with A=F0 -> out FF, following beat A=00 func=001 -> 00.
//  4. Reset asserted while out_valid=1 & out_ready=0 -> next cycle out_valid=0, logic_out=0, txn_count=0.
//  5. CNT_W=4: 17 accepts -> txn_count reads 1.
//  6. LOGIC_FLAGS_EN: A=B=5A func=010 -> logic_out=00, out_zero=1, out_parity=0; func=111 A=07 ->
//     out_zero=0, out_parity=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// Registered, parametrised bitwise logic unit with one output register slot.
// It takes operand beats through a valid/ready handshake and computes one of
// eight bitwise functions. The result is held in a single output register that
// tolerates downstream backpressure. In accumulate mode the previous accepted
// result stands in for operand B.
//
// Optional feature macro: LOGIC_FLAGS_EN
//   defined   -> out_zero / out_parity ports exist. They are registered
//                alongside logic_out.
//   undefined -> the flag ports and flag logic are absent.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
//   CNT_W      width of the accepted-beat counter
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    operand beat valid
//   in_ready    unit can take a beat this cycle (combinational)
//   A, B        operands (B ignored when acc_mode=1)
//   logic_func  function select: 000 AND, 001 OR, 010 XOR, 011 NOT A,
//               100 NAND, 101 NOR, 110 XNOR, 111 PASS A
//   acc_mode    1: operand B is replaced by the accumulator
//   acc_clr     clear the accumulator (wins over an update in the same cycle)
//   out_valid   logic_out holds an unconsumed result
//   out_ready   downstream consumes the result this cycle
//   logic_out   registered result
//   txn_count   accepted-beat count, wraps
//   out_zero    (LOGIC_FLAGS_EN) logic_out == 0
//   out_parity  (LOGIC_FLAGS_EN) XOR-reduce of logic_out
//
// Handshake: a beat transfers on a rising edge where in_valid & in_ready.
// A result transfers where out_valid & out_ready. in_ready = ~out_valid |
// out_ready, so a drain and a new accept can happen in the same cycle with no
// bubble. While out_valid & ~out_ready, every output register holds.
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       logic_func,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] logic_out,
  output logic [CNT_W-1:0] txn_count
`ifdef LOGIC_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  // Output slot state. out_valid is a direct decode of this register, so the
  // FSM state is always visible on the port.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam logic [2:0] FN_AND  = 3'b000;
  localparam logic [2:0] FN_OR   = 3'b001;
  localparam logic [2:0] FN_XOR  = 3'b010;
  localparam logic [2:0] FN_NOTA = 3'b011;
  localparam logic [2:0] FN_NAND = 3'b100;
  localparam logic [2:0] FN_NOR  = 3'b101;
  localparam logic [2:0] FN_XNOR = 3'b110;
  localparam logic [2:0] FN_PASS = 3'b111;

  slot_state_e      slot_q, slot_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] bop;
  logic [WIDTH-1:0] result;

  // ---------------------------------------------------------------------------
  // Handshake and datapath
  // ---------------------------------------------------------------------------
  assign out_valid = (slot_q == SLOT_FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  assign bop = acc_mode ? acc_q : B;

  always_comb begin
    result = '0;
    unique case (logic_func)
      FN_AND:  result = A & bop;
      FN_OR:   result = A | bop;
      FN_XOR:  result = A ^ bop;
      FN_NOTA: result = ~A;
      FN_NAND: result = ~(A & bop);
      FN_NOR:  result = ~(A | bop);
      FN_XNOR: result = ~(A ^ bop);
      FN_PASS: result = A;
      default: result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_d = slot_q;
    res_d  = res_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;

    // Output slot: an accept always fills it, which covers a drain and an
    // accept in the same cycle. A drain with no accept empties it. Otherwise
    // it holds. logic_out keeps its last value after a drain.
    if (accept) begin
      slot_d = SLOT_FULL;
      res_d  = result;
      cnt_d  = cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      slot_d = SLOT_EMPTY;
    end

    // The result above already used the old accumulator as Bop, so a
    // clear in the same cycle as an accept only affects the stored value.
    if (acc_clr) begin
      acc_d = '0;
    end else if (accept) begin
      acc_d = result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= SLOT_EMPTY;
      res_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      res_q  <= res_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign logic_out = res_q;
  assign txn_count = cnt_q;

`ifdef LOGIC_FLAGS_EN
  // ---------------------------------------------------------------------------
  // Result flags. They load on the same accept as res_q, so they always
  // describe logic_out. Reset values match a zero result.
  // ---------------------------------------------------------------------------
  logic zero_q, zero_d;
  logic par_q, par_d;

  always_comb begin
    zero_d = zero_q;
    par_d  = par_q;
    if (accept) begin
      zero_d = (result == '0);
      par_d  = ^result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
      par_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      par_q  <= par_d;
    end
  end

  assign out_zero   = zero_q;
  assign out_parity = par_q;
`endif

endmodule
